// File: rtl/mem_access_stage.sv
`default_nettype none
//==============================================================================
// Module      : mem_access_stage
// Description : Memory-access stage: LOAD/STORE via DMEM req/ack, ALU results
//               passed to writeback. Optional macro: DMEM_TIMEOUT_EN.
// Revision    : 1.0 - initial release
//==============================================================================

package simple_processor_pkg;
    localparam int ADDR_WIDTH = 16;
    localparam int DATA_WIDTH = 32;

    typedef enum logic [3:0] {
        FUNC_ADD   = 4'd0,
        FUNC_SUB   = 4'd1,
        FUNC_AND   = 4'd2,
        FUNC_OR    = 4'd3,
        FUNC_XOR   = 4'd4,
        FUNC_SLL   = 4'd5,
        FUNC_SRL   = 4'd6,
        FUNC_SLT   = 4'd7,
        FUNC_LOAD  = 4'd8,
        FUNC_STORE = 4'd9
    } func_t;
endpackage

module mem_access_stage
    import simple_processor_pkg::*;
#(
    parameter int MEM_ADDR_WIDTH = simple_processor_pkg::ADDR_WIDTH,
    parameter int MEM_DATA_WIDTH = simple_processor_pkg::DATA_WIDTH,
    parameter int RD_ADDR_WIDTH  = 5,
    parameter int TIMEOUT_CYCLES = 16
) (
    input  logic                      clk_i,
    input  logic                      arst_ni,
    input  logic                      valid_i,
    output logic                      ready_o,
    input  func_t                     func_i,
    input  logic [DATA_WIDTH-1:0]     addr_i,
    input  logic [DATA_WIDTH-1:0]     wdata_i,
    input  logic [DATA_WIDTH-1:0]     alu_result_i,
    input  logic [RD_ADDR_WIDTH-1:0]  rd_addr_i,
    output logic                      dmem_req_o,
    output logic [MEM_ADDR_WIDTH-1:0] dmem_addr_o,
    output logic                      dmem_we_o,
    output logic [MEM_DATA_WIDTH-1:0] dmem_wdata_o,
    input  logic [MEM_DATA_WIDTH-1:0] dmem_rdata_i,
    input  logic                      dmem_ack_i,
    output logic                      wb_valid_o,
    output logic                      wb_en_o,
    output logic [RD_ADDR_WIDTH-1:0]  wb_rd_addr_o,
    output logic [DATA_WIDTH-1:0]     wb_data_o,
    output logic                      dmem_err_o
);

    // S_ALU is a one-cycle alignment slot so ALU results retire two cycles
    // after the handshake, matching a memory op acked in its first MEM cycle.
    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_ALU  = 2'd1,
        S_MEM  = 2'd2,
        S_WB   = 2'd3
    } state_t;

    state_t                    state_q,   state_d;
    func_t                     func_q,    func_d;
    logic [MEM_ADDR_WIDTH-1:0] addr_q,    addr_d;
    logic [MEM_DATA_WIDTH-1:0] wdata_q,   wdata_d;
    logic [RD_ADDR_WIDTH-1:0]  rd_q,      rd_d;
    logic                      wb_en_q,   wb_en_d;
    logic [DATA_WIDTH-1:0]     wb_data_q, wb_data_d;

    logic [MEM_DATA_WIDTH-1:0] w_wdata_mem;
    logic [DATA_WIDTH-1:0]     w_rdata_core;
    logic                      w_in_mem;
    logic                      w_in_wb;
    logic                      w_is_store;

    function automatic logic func_is_alu(input func_t f);
        case (f)
            FUNC_ADD, FUNC_SUB, FUNC_AND, FUNC_OR,
            FUNC_XOR, FUNC_SLL, FUNC_SRL, FUNC_SLT: return 1'b1;
            default:                                return 1'b0;
        endcase
    endfunction

    generate
        if (MEM_ADDR_WIDTH < DATA_WIDTH) begin : g_addr_trunc
            logic unused_addr_hi;
            assign unused_addr_hi = ^addr_i[DATA_WIDTH-1:MEM_ADDR_WIDTH];
        end

        if (MEM_DATA_WIDTH == DATA_WIDTH) begin : g_data_same
            assign w_wdata_mem  = wdata_i;
            assign w_rdata_core = dmem_rdata_i;
        end else if (MEM_DATA_WIDTH < DATA_WIDTH) begin : g_data_narrow
            logic unused_wdata_hi;
            assign unused_wdata_hi = ^wdata_i[DATA_WIDTH-1:MEM_DATA_WIDTH];
            assign w_wdata_mem     = wdata_i[MEM_DATA_WIDTH-1:0];
            assign w_rdata_core    = {{(DATA_WIDTH-MEM_DATA_WIDTH){1'b0}}, dmem_rdata_i};
        end else begin : g_data_wide
            logic unused_rdata_hi;
            assign unused_rdata_hi = ^dmem_rdata_i[MEM_DATA_WIDTH-1:DATA_WIDTH];
            assign w_wdata_mem     = {{(MEM_DATA_WIDTH-DATA_WIDTH){1'b0}}, wdata_i};
            assign w_rdata_core    = dmem_rdata_i[DATA_WIDTH-1:0];
        end
    endgenerate

`ifdef DMEM_TIMEOUT_EN
    localparam logic [7:0] c_TMO_LAST = 8'(TIMEOUT_CYCLES - 1);

    logic [7:0] tmo_cnt_q, tmo_cnt_d;
    logic       err_q,     err_d;
`else
    logic unused_tmo_cfg;
    assign unused_tmo_cfg = ^TIMEOUT_CYCLES;
`endif

    always_comb begin
        state_d   = state_q;
        func_d    = func_q;
        addr_d    = addr_q;
        wdata_d   = wdata_q;
        rd_d      = rd_q;
        wb_en_d   = wb_en_q;
        wb_data_d = wb_data_q;
`ifdef DMEM_TIMEOUT_EN
        tmo_cnt_d = tmo_cnt_q;
        err_d     = err_q;
`endif

        case (state_q)
            S_IDLE: begin
                if (valid_i) begin
                    func_d  = func_i;
                    addr_d  = addr_i[MEM_ADDR_WIDTH-1:0];
                    wdata_d = w_wdata_mem;
                    rd_d    = rd_addr_i;
`ifdef DMEM_TIMEOUT_EN
                    tmo_cnt_d = 8'd0;
                    err_d     = 1'b0;
`endif
                    if (func_i == FUNC_LOAD || func_i == FUNC_STORE) begin
                        state_d   = S_MEM;
                        wb_en_d   = (func_i == FUNC_LOAD);
                        wb_data_d = '0;
                    end else begin
                        state_d   = S_ALU;
                        wb_en_d   = func_is_alu(func_i);
                        wb_data_d = alu_result_i;
                    end
                end
            end

            S_ALU: state_d = S_WB;

            S_MEM: begin
                // An ack in the final counted cycle beats the timeout.
                if (dmem_ack_i) begin
                    state_d = S_WB;
                    if (func_q == FUNC_LOAD) begin
                        wb_data_d = w_rdata_core;
                    end
                end
`ifdef DMEM_TIMEOUT_EN
                else if (tmo_cnt_q == c_TMO_LAST) begin
                    state_d = S_WB;
                    wb_en_d = 1'b0;
                    err_d   = 1'b1;
                end else begin
                    tmo_cnt_d = tmo_cnt_q + 8'd1;
                end
`endif
            end

            S_WB:    state_d = S_IDLE;
            default: state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge clk_i or negedge arst_ni) begin
        if (!arst_ni) begin
            state_q   <= S_IDLE;
            func_q    <= FUNC_ADD;
            addr_q    <= '0;
            wdata_q   <= '0;
            rd_q      <= '0;
            wb_en_q   <= 1'b0;
            wb_data_q <= '0;
        end else begin
            state_q   <= state_d;
            func_q    <= func_d;
            addr_q    <= addr_d;
            wdata_q   <= wdata_d;
            rd_q      <= rd_d;
            wb_en_q   <= wb_en_d;
            wb_data_q <= wb_data_d;
        end
    end

`ifdef DMEM_TIMEOUT_EN
    always_ff @(posedge clk_i or negedge arst_ni) begin
        if (!arst_ni) begin
            tmo_cnt_q <= 8'd0;
            err_q     <= 1'b0;
        end else begin
            tmo_cnt_q <= tmo_cnt_d;
            err_q     <= err_d;
        end
    end
`endif

    // Outputs decode from the state register only, so reset clears them at once.
    assign w_in_mem   = (state_q == S_MEM);
    assign w_in_wb    = (state_q == S_WB);
    assign w_is_store = (func_q == FUNC_STORE);

    assign ready_o      = (state_q == S_IDLE);
    assign dmem_req_o   = w_in_mem;
    assign dmem_addr_o  = w_in_mem ? addr_q : '0;
    assign dmem_we_o    = w_in_mem & w_is_store;
    assign dmem_wdata_o = (w_in_mem & w_is_store) ? wdata_q : '0;

    assign wb_valid_o   = w_in_wb;
    assign wb_en_o      = w_in_wb & wb_en_q;
    assign wb_rd_addr_o = w_in_wb ? rd_q : '0;
    assign wb_data_o    = w_in_wb ? wb_data_q : '0;

`ifdef DMEM_TIMEOUT_EN
    assign dmem_err_o = w_in_wb & err_q;
`else
    assign dmem_err_o = 1'b0;
`endif

endmodule

`default_nettype wire
